instr_seq_ctrl: RTL and testbench
=================================

Name: instr_seq_ctrl

Overview:
- Program sequencer for a synchronous-read instruction RAM; owns the program counter and fetches, decodes and executes one instruction at a time.
- Issues command words to a downstream datapath over a valid/ready handshake.
- Supports hardware loop counting, conditional and unconditional jumps (absolute and PC-relative), event waits and halt.
- Sits between the top-level control (start/halt status) and the instruction RAM / command datapath.

Parameters:
WIDTH_INSTR, 16, instruction word width; opcode = instr[WIDTH_INSTR-1 -: 4], operand = instr[WIDTH_INSTR-5:0]
WIDTH_ADDR, 8, instruction RAM address / PC width
WIDTH_CMD, 12, command word width driven on cmd_data (operand zero-extended or truncated)
NUM_EV, 8, number of event inputs (power of two, at most 2^(WIDTH_INSTR-4))

Ports:
clk  input  1  clock
rstn  input  1  asynchronous active-low reset
start  input  1  pulse; in IDLE or HALT begins execution at start_addr
start_addr  input  WIDTH_ADDR  entry point, sampled when start is accepted
mem_en  output  1  RAM read enable
mem_addr  output  WIDTH_ADDR  RAM read address (equals pc)
mem_rdata  input  WIDTH_INSTR  RAM data, valid one cycle after mem_en
cmd_valid  output  1  command word available
cmd_data  output  WIDTH_CMD  command word
cmd_ready  input  1  downstream accepts command
ev  input  NUM_EV  level-sensitive event flags
busy  output  1  high in any state except IDLE and HALT
halted  output  1  high in HALT
pc  output  WIDTH_ADDR  current program counter
loop_cnt  output  8  current loop counter

Behaviour:
- Reset: rstn is asynchronous, active-low; clock is clk. On reset: state=IDLE, pc=0, loop_cnt=0, mem_en=0, cmd_valid=0, cmd_data=0, busy=0, halted=0.
- States: IDLE, FETCH, EXEC, CMD, WAITEV, HALT.
- IDLE/HALT + start: pc<=start_addr, go to FETCH. start is ignored in every other state.
- FETCH (1 cycle): mem_en=1, mem_addr=pc; go to EXEC.
- EXEC (1 cycle): decode the mem_rdata captured this cycle and apply the next-PC rule below. Minimum instruction time is 2 cycles.
- Next-PC rule: default pc+1 modulo 2^WIDTH_ADDR. Relative target = pc + sign-extended operand[7:0], modulo 2^WIDTH_ADDR.
- Opcode 0000 NOP: pc+1, go to FETCH.
- Opcode 0001 OUT: cmd_data<=operand, cmd_valid<=1, go to CMD.
- Opcode 0010 WAIT: index = operand[log2(NUM_EV)-1:0]; if ev[index]=1 this cycle, pc+1 and FETCH, else go to WAITEV.
- Opcode 0011 LOOP: loop_cnt<=operand[7:0], pc+1, FETCH.
- Opcode 0100 DJNZ: loop_cnt<=loop_cnt-1. If the decremented value is nonzero, take the relative target, else pc+1. DJNZ with loop_cnt=0 wraps to 255 and jumps.
- Opcode 1001 JREL: take the relative target.
- Opcode 1010 JMP: pc<=operand[WIDTH_ADDR-1:0].
- Opcode 1111 HALT: pc unchanged, go to HALT, halted=1.
- Any other opcode: treated as NOP.
- CMD: hold cmd_valid and cmd_data stable until cmd_ready=1. On the handshake cycle: cmd_valid<=0, pc+1, FETCH. cmd_ready while cmd_valid=0 is ignored.
- WAITEV: re-samples ev[index] each cycle; index is held in a register latched in EXEC. When high: pc+1, FETCH. No timeout.
- Jump to self (JREL offset 0, or JMP to pc) is legal and loops forever until reset.
- Reset mid-operation: aborts immediately, including an outstanding cmd_valid; no command is completed.
- pc output always reflects the address of the instruction being fetched or executed.

Test Plan:
- Reset then start, start_addr=0x10, program NOP,NOP,HALT -> mem_addr 0x10,0x11,0x12; halted=1 on cycle 7 after start; pc=0x12.
- OUT 0x5A5 with cmd_ready low for 3 cycles -> cmd_valid high 4 cycles, cmd_data=0x5A5 stable, single handshake, then fetch of next address.
- LOOP 3 at 0x00; OUT 0x001 at 0x01; DJNZ -1 at 0x02; HALT at 0x03 -> exactly 3 commands, loop_cnt=0, halted at pc=0x03.
- WAIT ev[5] with ev[5] raised 10 cycles later -> busy stays high, pc constant, advances the cycle after ev[5] is seen; ev[4] toggling has no effect.
- JMP 0xFE then JREL +3 at 0xFE -> pc sequence 0xFE then 0x01 (wrap-around).
- rstn asserted while in CMD -> cmd_valid, busy and pc go to 0 asynchronously; state IDLE; later start runs normally.

Source files
------------

// File: rtl/instr_seq_ctrl.sv
// Program sequencer for a synchronous-read instruction RAM.
// Fetches, decodes and executes one instruction at a time and issues commands.
module instr_seq_ctrl #(
    parameter int WIDTH_INSTR = 16,
    parameter int WIDTH_ADDR  = 8,
    parameter int WIDTH_CMD   = 12,
    parameter int NUM_EV      = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic [WIDTH_ADDR-1:0]  start_addr,
    output logic                   mem_en,
    output logic [WIDTH_ADDR-1:0]  mem_addr,
    input  logic [WIDTH_INSTR-1:0] mem_rdata,
    output logic                   cmd_valid,
    output logic [WIDTH_CMD-1:0]   cmd_data,
    input  logic                   cmd_ready,
    input  logic [NUM_EV-1:0]      ev,
    output logic                   busy,
    output logic                   halted,
    output logic [WIDTH_ADDR-1:0]  pc,
    output logic [7:0]             loop_cnt
);

    localparam int WO  = WIDTH_INSTR - 4;
    localparam int W1  = (WO > WIDTH_CMD) ? WO : WIDTH_CMD;
    localparam int W2  = (W1 > WIDTH_ADDR) ? W1 : WIDTH_ADDR;
    localparam int WP  = (W2 > 8) ? W2 : 8;
    localparam int RW  = (WIDTH_ADDR > 8) ? WIDTH_ADDR : 8;
    localparam int EVW = (NUM_EV > 1) ? $clog2(NUM_EV) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_CMD    = 3'd3;
    localparam logic [2:0] S_WAITEV = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_OUT  = 4'b0001;
    localparam logic [3:0] OP_WAIT = 4'b0010;
    localparam logic [3:0] OP_LOOP = 4'b0011;
    localparam logic [3:0] OP_DJNZ = 4'b0100;
    localparam logic [3:0] OP_JREL = 4'b1001;
    localparam logic [3:0] OP_JMP  = 4'b1010;
    localparam logic [3:0] OP_HALT = 4'b1111;

    logic [2:0]            state;
    logic [EVW-1:0]        ev_idx;
    logic [3:0]            opcode;
    logic [WP-1:0]         opnd;
    logic signed [7:0]     off8;
    logic [RW-1:0]         offx;
    logic [WIDTH_ADDR-1:0] pc_inc;
    logic [WIDTH_ADDR-1:0] rel_tgt;
    logic [7:0]            loop_dec;
    logic [EVW-1:0]        ev_sel;
    logic                  unused_bits;

    // Operand padded so every field slice below is in range for any width.
    assign opcode   = mem_rdata[WIDTH_INSTR-1 -: 4];
    assign opnd     = WP'(mem_rdata[WO-1:0]);
    assign off8     = opnd[7:0];
    assign offx     = RW'(off8);
    assign pc_inc   = pc + WIDTH_ADDR'(1);
    assign rel_tgt  = pc + offx[WIDTH_ADDR-1:0];
    assign loop_dec = loop_cnt - 8'd1;
    assign ev_sel   = opnd[EVW-1:0];

    assign unused_bits = ^{opnd, offx};

    assign mem_en   = (state == S_FETCH);
    assign mem_addr = pc;
    assign busy     = (state != S_IDLE) && (state != S_HALT);
    assign halted   = (state == S_HALT);

    // Sequencer state, program counter, loop counter and command register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            pc        <= '0;
            loop_cnt  <= '0;
            cmd_valid <= 1'b0;
            cmd_data  <= '0;
            ev_idx    <= '0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        pc    <= start_addr;
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    case (opcode)
                        OP_OUT: begin
                            cmd_data  <= opnd[WIDTH_CMD-1:0];
                            cmd_valid <= 1'b1;
                            state     <= S_CMD;
                        end
                        OP_WAIT: begin
                            ev_idx <= ev_sel;
                            if (ev[ev_sel]) begin
                                pc    <= pc_inc;
                                state <= S_FETCH;
                            end else begin
                                state <= S_WAITEV;
                            end
                        end
                        OP_LOOP: begin
                            loop_cnt <= opnd[7:0];
                            pc       <= pc_inc;
                            state    <= S_FETCH;
                        end
                        OP_DJNZ: begin
                            loop_cnt <= loop_dec;
                            pc       <= (loop_dec != 8'd0) ? rel_tgt : pc_inc;
                            state    <= S_FETCH;
                        end
                        OP_JREL: begin
                            pc    <= rel_tgt;
                            state <= S_FETCH;
                        end
                        OP_JMP: begin
                            pc    <= opnd[WIDTH_ADDR-1:0];
                            state <= S_FETCH;
                        end
                        OP_HALT: begin
                            state <= S_HALT;
                        end
                        OP_NOP: begin
                            pc    <= pc_inc;
                            state <= S_FETCH;
                        end
                        default: begin
                            pc    <= pc_inc;
                            state <= S_FETCH;
                        end
                    endcase
                end
                S_CMD: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        pc        <= pc_inc;
                        state     <= S_FETCH;
                    end
                end
                S_WAITEV: begin
                    if (ev[ev_idx]) begin
                        pc    <= pc_inc;
                        state <= S_FETCH;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Directed testbench for instr_seq_ctrl.
// Models a synchronous-read instruction RAM and checks each step.
module tb_instr_seq_ctrl;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [7:0]  start_addr;
    logic        mem_en;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata;
    logic        cmd_valid;
    logic [11:0] cmd_data;
    logic        cmd_ready;
    logic [7:0]  ev;
    logic        busy;
    logic        halted;
    logic [7:0]  pc;
    logic [7:0]  loop_cnt;

    logic [15:0] mem [256];
    int checks;
    int errors;
    int hs_cnt;
    int hs_base;

    instr_seq_ctrl #(
        .WIDTH_INSTR(16),
        .WIDTH_ADDR (8),
        .WIDTH_CMD  (12),
        .NUM_EV     (8)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .start_addr(start_addr),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .cmd_valid (cmd_valid),
        .cmd_data  (cmd_data),
        .cmd_ready (cmd_ready),
        .ev        (ev),
        .busy      (busy),
        .halted    (halted),
        .pc        (pc),
        .loop_cnt  (loop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM: data appears the cycle after mem_en.
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= mem[mem_addr];
    end

    // Count completed command handshakes.
    always @(posedge clk) begin
        if (rstn && cmd_valid && cmd_ready) hs_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] a);
        start_addr = a;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_halt(input int budget);
        int n;
        n = 0;
        while (!halted && n < budget) begin
            step();
            n++;
        end
        chk("halt_reached", 32'(halted), 32'd1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        hs_cnt = 0;
        rstn = 1'b0;
        start = 1'b0;
        start_addr = 8'h00;
        cmd_ready = 1'b0;
        ev = 8'h00;
        mem_rdata = 16'h0000;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

        // Reset state
        #12;
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_loop", 32'(loop_cnt), 32'h0);
        chk("rst_mem_en", 32'(mem_en), 32'h0);
        chk("rst_cmd_valid", 32'(cmd_valid), 32'h0);
        chk("rst_cmd_data", 32'(cmd_data), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        rstn = 1'b1;
        step();

        // NOP, NOP, HALT at 0x10
        mem[8'h10] = 16'h0000;
        mem[8'h11] = 16'h0000;
        mem[8'h12] = 16'hF000;
        do_start(8'h10);
        chk("t1_fetch0_en", 32'(mem_en), 32'h1);
        chk("t1_fetch0_addr", 32'(mem_addr), 32'h10);
        chk("t1_busy", 32'(busy), 32'h1);
        step();
        chk("t1_exec0_en", 32'(mem_en), 32'h0);
        step();
        chk("t1_fetch1_addr", 32'(mem_addr), 32'h11);
        step();
        step();
        chk("t1_fetch2_addr", 32'(mem_addr), 32'h12);
        step();
        chk("t1_not_yet_halted", 32'(halted), 32'h0);
        step();
        chk("t1_halted", 32'(halted), 32'h1);
        chk("t1_pc", 32'(pc), 32'h12);
        chk("t1_busy_off", 32'(busy), 32'h0);

        // OUT 0x5A5 with backpressure for 3 cycles
        mem[8'h20] = 16'h15A5;
        mem[8'h21] = 16'hF000;
        hs_base = hs_cnt;
        do_start(8'h20);
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            chk("t2_valid_held", 32'(cmd_valid), 32'h1);
            chk("t2_data_held", 32'(cmd_data), 32'h5A5);
            chk("t2_pc_held", 32'(pc), 32'h20);
            step();
        end
        chk("t2_valid_4th", 32'(cmd_valid), 32'h1);
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        chk("t2_valid_drop", 32'(cmd_valid), 32'h0);
        chk("t2_next_fetch", 32'(mem_addr), 32'h21);
        chk("t2_next_en", 32'(mem_en), 32'h1);
        chk("t2_one_hs", 32'(hs_cnt - hs_base), 32'd1);
        wait_halt(20);

        // LOOP 3 / OUT 1 / DJNZ -1 / HALT
        mem[8'h00] = 16'h3003;
        mem[8'h01] = 16'h1001;
        mem[8'h02] = 16'h40FF;
        mem[8'h03] = 16'hF000;
        cmd_ready = 1'b1;
        hs_base = hs_cnt;
        do_start(8'h00);
        wait_halt(200);
        chk("t3_cmd_count", 32'(hs_cnt - hs_base), 32'd3);
        chk("t3_cmd_data", 32'(cmd_data), 32'h001);
        chk("t3_loop_cnt", 32'(loop_cnt), 32'h0);
        chk("t3_pc", 32'(pc), 32'h03);
        cmd_ready = 1'b0;

        // WAIT on ev[5], ev[4] toggling meanwhile
        mem[8'h30] = 16'h2005;
        mem[8'h31] = 16'hF000;
        do_start(8'h30);
        step();
        step();
        for (int i = 0; i < 10; i++) begin
            ev[4] = ~ev[4];
            chk("t4_busy", 32'(busy), 32'h1);
            chk("t4_pc_hold", 32'(pc), 32'h30);
            step();
        end
        chk("t4_no_fetch", 32'(mem_en), 32'h0);
        ev[5] = 1'b1;
        step();
        ev = 8'h00;
        chk("t4_pc_adv", 32'(pc), 32'h31);
        chk("t4_fetch", 32'(mem_en), 32'h1);
        wait_halt(20);

        // JMP 0xFE then JREL +3 wraps to 0x01
        mem[8'h40] = 16'hA0FE;
        mem[8'hFE] = 16'h9003;
        mem[8'h01] = 16'hF000;
        do_start(8'h40);
        step();
        step();
        chk("t5_pc_fe", 32'(pc), 32'hFE);
        step();
        step();
        chk("t5_pc_wrap", 32'(pc), 32'h01);
        wait_halt(20);
        chk("t5_halt_pc", 32'(pc), 32'h01);

        // Reset asserted while a command is outstanding
        mem[8'h50] = 16'h1123;
        mem[8'h51] = 16'hF000;
        hs_base = hs_cnt;
        do_start(8'h50);
        step();
        step();
        chk("t6_in_cmd", 32'(cmd_valid), 32'h1);
        #2;
        rstn = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(cmd_valid), 32'h0);
        chk("t6_rst_busy", 32'(busy), 32'h0);
        chk("t6_rst_pc", 32'(pc), 32'h0);
        chk("t6_rst_halted", 32'(halted), 32'h0);
        chk("t6_no_hs", 32'(hs_cnt - hs_base), 32'd0);
        #3;
        rstn = 1'b1;
        step();
        cmd_ready = 1'b1;
        do_start(8'h50);
        wait_halt(20);
        chk("t6_rerun_hs", 32'(hs_cnt - hs_base), 32'd1);
        chk("t6_rerun_pc", 32'(pc), 32'h51);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
